// File: rtl/state_dump_unit.sv
// state_dump_unit: streams every register, then a data-memory window, as (kind, addr, data) records over valid/ready.
// Build option `DUMP_SKIP_ZERO_EN suppresses records whose captured value is zero.
module state_dump_unit #(
   parameter int          NUM_REGS       = 32,
   parameter int          MEM_START_WORD = 16384,
   parameter int          MEM_WORDS      = 5,
   parameter logic [31:0] DATA_BASE      = 32'h10000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   output logic [29:0] dm_raddr,
   input  logic [31:0] dm_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_kind,
   output logic [31:0] out_addr,
   output logic [31:0] out_data
);
   typedef enum logic [2:0] {IDLE, REG, MEM, FLUSH, DONE} state_t;
   localparam logic [31:0] REG_LAST = 32'(NUM_REGS - 1);
   localparam logic [31:0] MEM_LAST = 32'(MEM_WORDS - 1);
   localparam logic [31:0] MEM_BASE = 32'(MEM_START_WORD);
   state_t state, state_n;
   logic [31:0] idx, word, cap_data;
   logic slot_free, cap, last, keep;
   assign slot_free = !out_valid || out_ready;
   assign cap = slot_free && (state == REG || state == MEM);
   assign last = (state == REG) ? idx == REG_LAST : idx == MEM_LAST;
   assign word = MEM_BASE + idx;
   assign cap_data = (state == REG) ? rf_rdata : dm_rdata;
`ifdef DUMP_SKIP_ZERO_EN
   assign keep = cap_data != 32'd0;
`else
   assign keep = 1'b1;
`endif
   always_ff @(posedge clk) state <= reset ? IDLE : state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = (NUM_REGS > 0) ? REG : (MEM_WORDS > 0) ? MEM : FLUSH;
         REG:     if (cap && last) state_n = (MEM_WORDS > 0) ? MEM : FLUSH;
         MEM:     if (cap && last) state_n = FLUSH;
         FLUSH:   if (!out_valid) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      busy = state != IDLE;
      done = state == DONE;
      rf_raddr = (state == REG) ? idx[4:0] : 5'd0;
      dm_raddr = (state == MEM) ? word[29:0] : 30'd0;
   end
   // idx only moves on a capture, so the read ports hold their index through a stall
   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= 32'd0;
         out_valid <= 1'b0;
         out_kind <= 1'b0;
         out_addr <= 32'd0;
         out_data <= 32'd0;
      end else if (cap) begin
         idx <= last ? 32'd0 : idx + 32'd1;
         out_valid <= keep;
         out_kind <= state == MEM;
         out_addr <= (state == MEM) ? DATA_BASE + (word << 2) : idx;
         out_data <= cap_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule
